// File: rtl/kernel_cc_pkg.sv
// Shared types and helpers for the kernel_cc start-token arbiter.
package kernel_cc_pkg;

  localparam int CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/kernel_cc_rr_pick.sv
// Round-robin picker: rotate requests by ptr, take the lowest set bit,
// rotate the result back to an absolute one-hot grant and index.
module kernel_cc_rr_pick
  import kernel_cc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     idx_sum;

  // rot[k] is the requester k places after ptr, modulo NUM_REQ
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] pos;
      assign sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign pos     = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
      assign rot[gi] = req[pos];
    end
  endgenerate

  always_comb begin
    any = 1'b0;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = IDX_W'(i);
      end
    end
  end

  assign idx_sum = {1'b0, ptr} + {1'b0, off};
  assign idx     = (idx_sum >= N_W) ? IDX_W'(idx_sum - N_W) : IDX_W'(idx_sum);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/kernel_cc_start_token_arbiter.sv
// Credit-limited round-robin merge of start-token FIFOs with drain handshake.
// Optional per-requester grant counters: define KERNEL_CC_START_ARB_STATS_EN.
module kernel_cc_start_token_arbiter
  import kernel_cc_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int TAG_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_empty_n,
  output logic [NUM_REQ-1:0]           req_read,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [TAG_WIDTH-1:0]         out_din,
  input  logic                         done,
  input  logic                         drain,
  output logic                         drained,
`ifdef KERNEL_CC_START_ARB_STATS_EN
  output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt,
`endif
  output logic [CNT_WIDTH-1:0]         inflight
);

  localparam int                   IDX_W   = clog2(NUM_REQ);
  localparam logic [IDX_W:0]       N_W     = (IDX_W+1)'(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  arb_state_t           state_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     ptr_next;
  logic [IDX_W:0]       ptr_inc;
  logic [CNT_WIDTH-1:0] inflight_reg;
  logic [CNT_WIDTH-1:0] inflight_next;
  logic                 drained_reg;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 grant_ok;
  logic                 credit_ret;

  kernel_cc_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req  (req_empty_n),
    .ptr  (ptr_reg),
    .any  (pick_any),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  // drain is checked directly so the cycle that requests the drain grants nothing
  assign grant_ok = !reset && (state_reg == ST_RUN) && !drain && out_full_n
                    && (inflight_reg < MAX_CNT) && pick_any;

  assign req_read  = grant_ok ? pick_grant : '0;
  assign out_write = grant_ok;
  assign out_din   = grant_ok ? TAG_WIDTH'(pick_idx) : '0;
  assign inflight  = inflight_reg;
  assign drained   = drained_reg;

  // a completion with nothing outstanding is spurious and dropped
  assign credit_ret = done && (inflight_reg != '0);

  always_comb begin
    inflight_next = inflight_reg;
    case ({grant_ok, credit_ret})
      2'b10:   inflight_next = inflight_reg + ONE;
      2'b01:   inflight_next = inflight_reg - ONE;
      default: ;
    endcase
  end

  assign ptr_inc  = {1'b0, pick_idx} + (IDX_W+1)'(1);
  assign ptr_next = (ptr_inc >= N_W) ? '0 : IDX_W'(ptr_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      ptr_reg      <= '0;
      inflight_reg <= '0;
      drained_reg  <= 1'b0;
    end else begin
      inflight_reg <= inflight_next;
      if (grant_ok) ptr_reg <= ptr_next;
      case (state_reg)
        ST_RUN: begin
          drained_reg <= 1'b0;
          if (drain) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain) begin
            state_reg <= ST_RUN;
          end else if (inflight_next == '0) begin
            state_reg   <= ST_DRAINED;
            drained_reg <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain) begin
            state_reg   <= ST_RUN;
            drained_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_RUN;
          drained_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef KERNEL_CC_START_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (req_read[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + ONE;
        end
      end
      assign grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_kernel_cc_start_token_arbiter.sv
// Directed bench for the start-token arbiter; expected values computed by hand.
module tb_kernel_cc_start_token_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_empty_n;
  logic [3:0] req_read;
  logic       out_full_n;
  logic       out_write;
  logic [1:0] out_din;
  logic       done;
  logic       drain;
  logic       drained;
  logic [7:0] inflight;
`ifdef KERNEL_CC_START_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kernel_cc_start_token_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_empty_n(req_empty_n),
    .req_read   (req_read),
    .out_full_n (out_full_n),
    .out_write  (out_write),
    .out_din    (out_din),
    .done       (done),
    .drain      (drain),
    .drained    (drained),
`ifdef KERNEL_CC_START_ARB_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .inflight   (inflight)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("[%0t] %s = %0d", $time, tag, obs);
    end else begin
      $display("[%0t] FAIL %s: got %0d, expected %0d", $time, tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // outputs are sampled mid-cycle, 4ns after inputs settle
  task automatic settle();
    #4;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    settle();
    chk({tag, ".out_write"}, int'(out_write), 1);
    chk({tag, ".out_din"}, int'(out_din), idx);
    chk({tag, ".req_read"}, int'(req_read), 1 << idx);
  endtask

  task automatic expect_idle(input string tag);
    settle();
    chk({tag, ".out_write"}, int'(out_write), 0);
    chk({tag, ".req_read"}, int'(req_read), 0);
  endtask

  initial begin
    int seq1 [5] = '{0, 1, 2, 3, 0};
    int seq3 [4] = '{2, 3, 0, 1};

    reset = 1'b1; req_empty_n = 4'b0000; out_full_n = 1'b1;
    done = 1'b0; drain = 1'b0;
    tick(); tick();
    req_empty_n = 4'b1111;
    settle();
    chk("rst.out_write_gated", int'(out_write), 0);
    chk("rst.inflight", int'(inflight), 0);
    chk("rst.drained", int'(drained), 0);
    chk("rst.out_din", int'(out_din), 0);
    tick();
    reset = 1'b0;

    // Scenario 1: all requesting, done returns the previous grant's credit
    for (int k = 0; k < 5; k++) begin
      req_empty_n = 4'b1111;
      done = (k > 0);
      expect_grant($sformatf("s1.g%0d", k), seq1[k]);
      tick();
    end
    chk("s1.inflight", int'(inflight), 1);
    req_empty_n = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    settle();
    chk("s1.inflight_clear", int'(inflight), 0);
`ifdef KERNEL_CC_START_ARB_STATS_EN
    chk("s1.cnt0", int'(grant_cnt[7:0]), 2);
    chk("s1.cnt1", int'(grant_cnt[15:8]), 1);
    chk("s1.cnt2", int'(grant_cnt[23:16]), 1);
    chk("s1.cnt3", int'(grant_cnt[31:24]), 1);
`endif
    tick();

    // Scenario 2: ptr=1; grant 2 moves ptr to 3, then wrap cases
    req_empty_n = 4'b0100;
    expect_grant("s2.setup", 2);
    tick();
    req_empty_n = 4'b0100;
    expect_grant("s2.wrap", 2);
    tick();
    req_empty_n = 4'b0101;
    expect_grant("s2.wrap0", 0);
    tick();
    req_empty_n = 4'b0000;
    settle();
    chk("s2.inflight", int'(inflight), 3);

    // Scenario 5: drain with three tokens outstanding (ptr=1)
    req_empty_n = 4'b1111; drain = 1'b1;
    expect_idle("s5.req_cycle");
    tick();
    expect_idle("s5.drain0");
    done = 1'b1; tick();
    done = 1'b0; tick();
    done = 1'b1; tick();
    settle();
    chk("s5.inflight1", int'(inflight), 1);
    chk("s5.not_drained", int'(drained), 0);
    chk("s5.no_grant", int'(out_write), 0);
    tick();
    done = 1'b0;
    settle();
    chk("s5.drained", int'(drained), 1);
    chk("s5.inflight0", int'(inflight), 0);
    tick();
    drain = 1'b0;
    expect_idle("s5.exit_cycle");
    tick();
    expect_grant("s5.resume", 1);
    chk("s5.drained_clear", int'(drained), 0);
    tick();

    // Scenario 3: credit limit (clear the one credit first; ptr=2)
    req_empty_n = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_empty_n = 4'b1111;
      expect_grant($sformatf("s3.g%0d", k), seq3[k]);
      tick();
    end
    settle();
    chk("s3.inflight_full", int'(inflight), 4);
    tick();
    for (int k = 0; k < 3; k++) begin
      expect_idle($sformatf("s3.blocked%0d", k));
      tick();
    end
    done = 1'b1;
    expect_idle("s3.done_same_cycle");
    tick();
    done = 1'b0;
    expect_grant("s3.unblocked", 2);
    tick();

    // Scenario 6: grant+done at inflight=2, spurious done at 0 (ptr=3)
    req_empty_n = 4'b0000; done = 1'b1;
    tick(); tick();
    req_empty_n = 4'b1111;
    expect_grant("s6.grant_done", 3);
    tick();
    req_empty_n = 4'b0000;
    settle();
    chk("s6.inflight_hold", int'(inflight), 2);
    tick(); tick(); tick();
    done = 1'b0;
    settle();
    chk("s6.inflight_sat0", int'(inflight), 0);
    tick();

    // Scenario 4: downstream full holds pointer (ptr=0 -> 2 after setup)
    req_empty_n = 4'b0010;
    expect_grant("s4.setup", 1);
    tick();
    out_full_n = 1'b0; req_empty_n = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_idle($sformatf("s4.full%0d", k));
      tick();
    end
    out_full_n = 1'b1;
    expect_grant("s4.resume", 2);
    tick();
    settle();
    chk("s4.inflight", int'(inflight), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
